// File: rtl/code_entry_controller.sv
// Keypad lock controller: assembles one-hot button pulses into a multi-digit
// code, checks it against a stored code, supports code change and lockout.
module code_entry_controller #(
  parameter int                          CODE_LENGTH    = 4,
  parameter logic [CODE_LENGTH*2-1:0]    DEFAULT_CODE   = 8'h1B,
  parameter int                          MAX_ATTEMPTS   = 3,
  parameter int                          TIMEOUT_CYCLES = 50000000,
  parameter int                          LOCKOUT_CYCLES = 250000000
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [3:0]                           buttonPresses,
  output logic                                 locked,
  output logic                                 lockoutActive,
  output logic                                 errorPulse,
  output logic                                 setDonePulse,
  output logic [$clog2(CODE_LENGTH+1)-1:0]     digitCount,
  output logic [2:0]                           stateOut
);

  localparam int CW   = CODE_LENGTH * 2;
  localparam int DCW  = $clog2(CODE_LENGTH + 1);
  localparam int TMAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = 4;

  localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [DCW-1:0] DIGITS_LAST  = DCW'(CODE_LENGTH - 1);
  localparam logic [FW-1:0]  FAIL_LIMIT   = FW'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    ST_LOCKED   = 3'd0,
    ST_ENTER    = 3'd1,
    ST_CHECK    = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_SET_CODE = 3'd4,
    ST_LOCKOUT  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   stored_code_q, stored_code_d;
  logic [CW-1:0]   entry_q, entry_d;
  logic [DCW-1:0]  digit_count_q, digit_count_d;
  logic [FW-1:0]   fail_count_q, fail_count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            error_pulse_q, error_pulse_d;
  logic            set_done_q, set_done_d;

  logic            press_valid;
  logic [1:0]      press_digit;
  logic [1:0]      idx_terms [4];
  logic [CW-1:0]   entry_shifted;
  logic            timer_restart;
  logic            timer_run;

  // With exactly one bit set, OR-ing the per-bit indices yields that bit's index.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_idx
      assign idx_terms[gi] = buttonPresses[gi] ? 2'(gi) : 2'd0;
    end
  endgenerate

  assign press_valid   = (buttonPresses != 4'd0) &&
                         ((buttonPresses & (buttonPresses - 4'd1)) == 4'd0);
  assign press_digit   = idx_terms[0] | idx_terms[1] | idx_terms[2] | idx_terms[3];
  assign entry_shifted = {entry_q[CW-3:0], press_digit};

  always_comb begin
    state_d       = state_q;
    stored_code_d = stored_code_q;
    entry_d       = entry_q;
    digit_count_d = digit_count_q;
    fail_count_d  = fail_count_q;
    error_pulse_d = 1'b0;
    set_done_d    = 1'b0;
    timer_restart = 1'b0;
    timer_run     = 1'b0;

    case (state_q)
      ST_LOCKED: begin
        if (press_valid) begin
          entry_d       = entry_shifted;
          digit_count_d = DCW'(1);
          state_d       = ST_ENTER;
        end
      end
      ST_ENTER: begin
        timer_run = 1'b1;
        if (press_valid) begin
          entry_d       = entry_shifted;
          digit_count_d = digit_count_q + DCW'(1);
          timer_restart = 1'b1;
          if (digit_count_q == DIGITS_LAST) state_d = ST_CHECK;
        end else if (timer_q == TIMEOUT_LAST) begin
          digit_count_d = '0;
          state_d       = ST_LOCKED;
        end
      end
      ST_CHECK: begin
        digit_count_d = '0;
        if (entry_q == stored_code_q) begin
          fail_count_d = '0;
          state_d      = ST_UNLOCKED;
        end else begin
          error_pulse_d = 1'b1;
          fail_count_d  = fail_count_q + FW'(1);
          state_d       = (fail_count_d == FAIL_LIMIT) ? ST_LOCKOUT : ST_LOCKED;
        end
      end
      ST_UNLOCKED: begin
        // Only buttons 3 (relock) and 0 (start code change) act here.
        if (press_valid) begin
          if (press_digit == 2'd3) begin
            state_d = ST_LOCKED;
          end else if (press_digit == 2'd0) begin
            digit_count_d = '0;
            state_d       = ST_SET_CODE;
          end
        end
      end
      ST_SET_CODE: begin
        timer_run = 1'b1;
        if (press_valid) begin
          entry_d       = entry_shifted;
          timer_restart = 1'b1;
          if (digit_count_q == DIGITS_LAST) begin
            stored_code_d = entry_shifted;
            set_done_d    = 1'b1;
            digit_count_d = '0;
            state_d       = ST_UNLOCKED;
          end else begin
            digit_count_d = digit_count_q + DCW'(1);
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          digit_count_d = '0;
          state_d       = ST_UNLOCKED;
        end
      end
      ST_LOCKOUT: begin
        timer_run = 1'b1;
        if (timer_q == LOCKOUT_LAST) begin
          fail_count_d = '0;
          state_d      = ST_LOCKED;
        end
      end
      default: begin
        digit_count_d = '0;
        state_d       = ST_LOCKED;
      end
    endcase

    // Idle/lockout timer restarts on any state change or accepted digit.
    if ((state_d != state_q) || timer_restart || !timer_run) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_LOCKED;
      stored_code_q <= DEFAULT_CODE;
      entry_q       <= '0;
      digit_count_q <= '0;
      fail_count_q  <= '0;
      timer_q       <= '0;
      error_pulse_q <= 1'b0;
      set_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      stored_code_q <= stored_code_d;
      entry_q       <= entry_d;
      digit_count_q <= digit_count_d;
      fail_count_q  <= fail_count_d;
      timer_q       <= timer_d;
      error_pulse_q <= error_pulse_d;
      set_done_q    <= set_done_d;
    end
  end

  assign locked        = !((state_q == ST_UNLOCKED) || (state_q == ST_SET_CODE));
  assign lockoutActive = (state_q == ST_LOCKOUT);
  assign stateOut      = state_q;
  assign errorPulse    = error_pulse_q;
  assign setDonePulse  = set_done_q;
  assign digitCount    = digit_count_q;

endmodule
